// File: rtl/sdram_rr_arbiter_if.sv
// Bundle of the three requester ports, the SDRAM controller port and status outputs.
// master = requesters plus SDRAM controller side, slave = the arbiter.
interface sdram_rr_arbiter_if #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 16
);
    logic              aud_req;
    logic [ADDR_W-1:0] aud_addr;
    logic              aud_ack;
    logic [DATA_W-1:0] aud_rddata;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_ack;
    logic [DATA_W-1:0] vid_rddata;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic [ADDR_W-1:0] avl_addr;
    logic              avl_read;
    logic              avl_write;
    logic [DATA_W-1:0] avl_wrdata;
    logic [DATA_W-1:0] avl_rddata;
    logic              avl_ack;
    logic [1:0]        grant;
    logic              err_timeout;

    modport master (
        output aud_req, aud_addr, vid_req, vid_addr, wr_req, wr_addr, wr_data,
               avl_rddata, avl_ack,
        input  aud_ack, aud_rddata, vid_ack, vid_rddata, wr_ack,
               avl_addr, avl_read, avl_write, avl_wrdata, grant, err_timeout
    );

    modport slave (
        input  aud_req, aud_addr, vid_req, vid_addr, wr_req, wr_addr, wr_data,
               avl_rddata, avl_ack,
        output aud_ack, aud_rddata, vid_ack, vid_rddata, wr_ack,
               avl_addr, avl_read, avl_write, avl_wrdata, grant, err_timeout
    );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// One-transaction-per-grant scheduler for the SDRAM master port: fixed read priority
// (audio > video > write), write aging after STARVE_LIMIT reader grants, and a BUSY watchdog.
module sdram_rr_arbiter #(
    parameter int ADDR_W         = 26,
    parameter int DATA_W         = 16,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk50,
    input  logic               reset,
    sdram_rr_arbiter_if.slave  bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nxt;
    logic [1:0]        win;
    logic [3:0]        starve_cnt, starve_nxt;
    logic [7:0]        wd_cnt;
    logic [1:0]        owner_q;
    logic              rd_q, wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wrdata_q;
    logic              ack_ok, timeout;

    always_comb begin
        state_nxt  = state;
        win        = 2'd0;
        starve_nxt = starve_cnt;
        ack_ok     = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wr_req && starve_cnt >= STARVE_LIM) win = 2'd3;
                else if (bus.aud_req)                       win = 2'd1;
                else if (bus.vid_req)                       win = 2'd2;
                else if (bus.wr_req)                        win = 2'd3;
                if (win != 2'd0) state_nxt = BUSY;
            end
            BUSY: begin
                // an ack landing on the last watchdog cycle still completes normally
                ack_ok  = bus.avl_ack;
                timeout = !bus.avl_ack && (wd_cnt == WD_LAST);
                if (ack_ok || timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!bus.wr_req || win == 2'd3)            starve_nxt = 4'd0;
        else if (win != 2'd0 && starve_cnt != 4'hF) starve_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            wd_cnt     <= 8'd0;
            owner_q    <= 2'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wrdata_q   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            if (state == IDLE && win != 2'd0) begin
                owner_q  <= win;
                rd_q     <= (win != 2'd3);
                wr_q     <= (win == 2'd3);
                addr_q   <= (win == 2'd1) ? bus.aud_addr :
                            (win == 2'd2) ? bus.vid_addr : bus.wr_addr;
                wrdata_q <= (win == 2'd3) ? bus.wr_data : '0;
                wd_cnt   <= 8'd0;
            end else if (state == BUSY) begin
                if (ack_ok || timeout) begin
                    owner_q <= 2'd0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end else begin
                    wd_cnt <= wd_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.avl_addr    = addr_q;
    assign bus.avl_wrdata  = wrdata_q;
    assign bus.avl_read    = rd_q;
    assign bus.avl_write   = wr_q;
    assign bus.grant       = owner_q;
    assign bus.err_timeout = timeout;

    // completion and read data reach only the current owner
    assign bus.aud_ack    = ack_ok && (owner_q == 2'd1);
    assign bus.vid_ack    = ack_ok && (owner_q == 2'd2);
    assign bus.wr_ack     = ack_ok && (owner_q == 2'd3);
    assign bus.aud_rddata = (bus.aud_ack && rd_q) ? bus.avl_rddata : '0;
    assign bus.vid_rddata = (bus.vid_ack && rd_q) ? bus.avl_rddata : '0;
endmodule
